// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
//   Shared definitions for the next-PC controller: FSM state encoding and a
//   small decode helper that debug/trace logic can reuse.
//   No ports (package).
package pc_sequencer_pkg;

  // 2-bit state encoding. Only FETCH and HALT are ever entered; the unused
  // encodings behave exactly like FETCH so a corrupted register self-recovers.
  typedef enum logic [1:0] {
    ST_FETCH       = 2'b00,
    ST_HALT        = 2'b01,
    ST_HALT_UNUSED = 2'b10,
    ST_RESERVED    = 2'b11
  } pc_state_t;

  // True only for the real HALT encoding; everything else decodes to FETCH.
  function automatic logic is_halt_state(input pc_state_t s);
    return (s == ST_HALT);
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf
//   One-entry redirect target buffer. Captures a jump/branch target that
//   arrives while the sequencer cannot advance, and presents either the live
//   redirect (this cycle's request) or the buffered one to the pc_next mux.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   load_en         capture live redirect this cycle if one is present
//   clear           drop the buffered entry (consumed by an advance)
//   jump/jump_target, branch_taken/branch_target   live redirect requests
//   pending         buffered entry valid
//   sel_valid       a redirect (live or buffered) is available
//   sel_target      chosen redirect target (jump > branch > buffered)
module pc_redirect_buf #(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic                 clear,
  input  logic                 jump,
  input  logic [BUS_WIDTH-1:0] jump_target,
  input  logic                 branch_taken,
  input  logic [BUS_WIDTH-1:0] branch_target,
  output logic                 pending,
  output logic                 sel_valid,
  output logic [BUS_WIDTH-1:0] sel_target
);

  logic                 live_valid;
  logic [BUS_WIDTH-1:0] live_target;
  logic [BUS_WIDTH-1:0] held_target;

  // Jump always beats a simultaneous branch.
  assign live_valid  = jump | branch_taken;
  assign live_target = jump ? jump_target : branch_target;

  // A newer request overwrites an older buffered one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= 1'b0;
      held_target <= '0;
    end else if (clear) begin
      pending <= 1'b0;
    end else if (load_en && live_valid) begin
      pending     <= 1'b1;
      held_target <= live_target;
    end
  end

  // Bypass: a live request takes precedence over the buffered target.
  assign sel_valid  = live_valid | pending;
  assign sel_target = live_valid ? live_target : held_target;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Next-PC controller. Computes pc_next every cycle from pc, the imem fetch
//   handshake, branch/jump redirects, stall and halt/resume. The external pc
//   register has no enable, so holding means pc_next = pc.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   pc                           current pc register value
//   imem_ready                   imem completes the fetch at pc this cycle
//   stall                        hold pc and drop imem_req
//   branch_taken/branch_target   conditional redirect
//   jump/jump_target             unconditional redirect
//   halt_req, resume             enter / leave HALT
//   pc_next                      value for the pc register (combinational)
//   imem_req                     fetch request for pc
//   fetch_valid                  fetch at pc completed this cycle
//   halted                       sequencer is in HALT (registered)
//   redirect_pending             buffered redirect awaiting next advance
//   fetch_count                  completed fetches since reset (wrapping)
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                   BUS_WIDTH    = 16,
  parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                   PC_STEP      = 1,
  parameter int                   CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] pc,
  input  logic                 imem_ready,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [BUS_WIDTH-1:0] branch_target,
  input  logic                 jump,
  input  logic [BUS_WIDTH-1:0] jump_target,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic [BUS_WIDTH-1:0] pc_next,
  output logic                 imem_req,
  output logic                 fetch_valid,
  output logic                 halted,
  output logic                 redirect_pending,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  pc_state_t            state;
  logic                 in_halt;
  logic                 advance;
  logic                 redirect_valid;
  logic [BUS_WIDTH-1:0] redirect_target;
  logic [BUS_WIDTH-1:0] step_pc;

  assign in_halt = is_halt_state(state);
  assign step_pc = pc + BUS_WIDTH'(PC_STEP);

  // imem_req depends only on state, stall and rst, so there is no path from
  // imem_ready back into the request.
  assign imem_req    = !rst && !in_halt && !stall;
  assign advance     = imem_req && imem_ready;
  assign fetch_valid = advance;

  // Redirects that arrive when we cannot advance (waiting, stalled or halted)
  // are parked here; an advance consumes or discards the parked entry.
  pc_redirect_buf #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_redirect_buf (
    .clk          (clk),
    .rst          (rst),
    .load_en      (!advance),
    .clear        (advance),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pending      (redirect_pending),
    .sel_valid    (redirect_valid),
    .sel_target   (redirect_target)
  );

  // pc only moves on an advance; otherwise it is held by feeding it back.
  always_comb begin
    pc_next = pc;
    if (rst) begin
      pc_next = RESET_VECTOR;
    end else if (advance) begin
      pc_next = redirect_valid ? redirect_target : step_pc;
    end
  end

  // FSM with registered halted flag and the fetch counter. halt_req is only
  // honoured together with an advance; resume wins over halt_req in HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FETCH;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        ST_HALT: begin
          if (resume) begin
            state  <= ST_FETCH;
            halted <= 1'b0;
          end
        end
        default: begin
          if (advance && halt_req) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state  <= ST_FETCH;
            halted <= 1'b0;
          end
        end
      endcase
      if (advance) begin
        fetch_count <= fetch_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
